// File: rtl/div_unit.sv
// Iterative RV32M DIV/DIVU/REM/REMU unit, radix-2 restoring, one quotient bit per cycle.
// Latency: done 33 cycles after accept (general), 1 cycle (divide-by-zero / signed overflow).
// Backpressure: busy blocks new starts; start while busy is dropped, flush aborts at the next edge.
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_nrst,
  input  logic            i_start,
  input  logic [1:0]      i_op,
  input  logic [XLEN-1:0] i_rs1_dat,
  input  logic [XLEN-1:0] i_rs2_dat,
  input  logic [4:0]      i_rd_sel,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_wb_en,
  output logic [4:0]      o_wb_sel,
  output logic [XLEN-1:0] o_wb_dat
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [1:0]      r_op;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_dvs;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_wb_dat;
  logic            r_neg_q;
  logic            r_neg_r;

  // Operand conditioning at accept: op[0]=0 marks the signed variants.
  logic            w_signed;
  logic            w_s1;
  logic            w_s2;
  logic [XLEN-1:0] w_abs1;
  logic [XLEN-1:0] w_abs2;
  logic            w_div0;
  logic            w_ovf;
  logic            w_accept;

  assign w_signed = ~i_op[0];
  assign w_s1     = w_signed & i_rs1_dat[XLEN-1];
  assign w_s2     = w_signed & i_rs2_dat[XLEN-1];
  assign w_abs1   = w_s1 ? (~i_rs1_dat + 1'b1) : i_rs1_dat;
  assign w_abs2   = w_s2 ? (~i_rs2_dat + 1'b1) : i_rs2_dat;
  assign w_div0   = (i_rs2_dat == '0);
  assign w_ovf    = w_signed && (i_rs1_dat == {1'b1, {(XLEN-1){1'b0}}}) && (i_rs2_dat == '1);
  assign w_accept = (r_state == S_IDLE) && i_start && !i_flush;

  // One restoring step: the partial remainder is always below the divisor, so the
  // shifted value fits XLEN+1 bits and the borrow bit alone gives the quotient bit.
  logic [XLEN:0]   w_shift;
  logic [XLEN:0]   w_diff;
  logic            w_ge;

  assign w_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_ge    = ~w_diff[XLEN];

  // Sign fixup and result select; negating a 0x80000000 magnitude wraps back to itself.
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic [XLEN-1:0] w_res;

  assign w_q_fix = r_neg_q ? (~r_quo + 1'b1) : r_quo;
  assign w_r_fix = r_neg_r ? (~r_rem + 1'b1) : r_rem;
  assign w_res   = r_op[1] ? w_r_fix : w_q_fix;

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    w_next = r_state;
    if (i_flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (i_start) w_next = (w_div0 || w_ovf) ? S_FIXUP : S_CALC;
        S_CALC:  if (r_cnt == '0) w_next = S_FIXUP;
        S_FIXUP: w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Datapath: latch operands at accept, iterate in CALC, capture the result in FIXUP.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_rd     <= '0;
      r_dvs    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_wb_dat <= '0;
    end else if (w_accept) begin
      r_op  <= i_op;
      r_rd  <= i_rd_sel;
      r_cnt <= CW'(XLEN-1);
      r_dvs <= w_abs2;
      if (w_div0) begin
        r_quo   <= '1;
        r_rem   <= i_rs1_dat;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else if (w_ovf) begin
        r_quo   <= {1'b1, {(XLEN-1){1'b0}}};
        r_rem   <= '0;
        r_neg_q <= 1'b0;
        r_neg_r <= 1'b0;
      end else begin
        r_quo   <= w_abs1;
        r_rem   <= '0;
        r_neg_q <= w_s1 ^ w_s2;
        r_neg_r <= w_s1;
      end
    end else if (r_state == S_CALC && !i_flush) begin
      r_rem <= w_ge ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
      r_quo <= {r_quo[XLEN-2:0], w_ge};
      r_cnt <= r_cnt - CW'(1);
    end else if (r_state == S_FIXUP && !i_flush) begin
      r_wb_dat <= w_res;
    end
  end

  assign o_busy   = (r_state != S_IDLE);
  assign o_done   = (r_state == S_DONE);
  assign o_wb_en  = o_done && (r_rd != 5'd0);
  assign o_wb_sel = r_rd;
  assign o_wb_dat = r_wb_dat;

endmodule

// File: tb/tb_div_unit.sv
// Directed-vector bench for div_unit.
// Expected results and latencies are hand-computed constants.
// Drives and samples on the falling edge, away from the active edge.
module tb_div_unit;

  logic        clk   = 1'b0;
  logic        nrst  = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op    = 2'd0;
  logic [31:0] rs1   = '0;
  logic [31:0] rs2   = '0;
  logic [4:0]  rd    = '0;
  logic        busy, done, wb_en;
  logic [4:0]  wb_sel;
  logic [31:0] wb_dat;

  int n_vec = 0, n_err = 0;
  int cyc = 0, t0 = 0;
  int done_cnt = 0, en_cnt = 0, base_done = 0, base_en = 0;

  localparam logic [1:0] DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11;

  div_unit #(.XLEN(32)) dut (
    .i_clk(clk), .i_nrst(nrst), .i_start(start), .i_op(op),
    .i_rs1_dat(rs1), .i_rs2_dat(rs2), .i_rd_sel(rd), .i_flush(flush),
    .o_busy(busy), .o_done(done), .o_wb_en(wb_en), .o_wb_sel(wb_sel), .o_wb_dat(wb_dat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done)  done_cnt++;
    if (wb_en) en_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a request for one cycle; returns at the falling edge after the accept edge.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] r);
    @(negedge clk);
    base_done = done_cnt;
    base_en   = en_cnt;
    op = o; rs1 = a; rs2 = b; rd = r; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
  endtask

  // Bounded wait for done; leaves the bench inside the done cycle.
  task automatic wait_done(input string tag, input int exp_lat);
    int k = 0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
    end
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " latency"}, 32'(cyc - t0), 32'(exp_lat));
    check({tag, " busy_in_done"}, 32'(busy), 32'd1);
  endtask

  task automatic finish_op(input string tag, input int exp_lat, input logic [31:0] exp_dat,
                           input logic [4:0] exp_sel, input logic exp_en);
    wait_done(tag, exp_lat);
    check({tag, " wb_dat"}, wb_dat, exp_dat);
    check({tag, " wb_sel"}, 32'(wb_sel), 32'(exp_sel));
    check({tag, " wb_en"}, 32'(wb_en), 32'(exp_en));
    @(negedge clk);
    #1;
    check({tag, " done_after"}, 32'(done), 32'd0);
    check({tag, " busy_after"}, 32'(busy), 32'd0);
    check({tag, " hold_dat"}, wb_dat, exp_dat);
    check({tag, " done_pulses"}, 32'(done_cnt - base_done), 32'd1);
    check({tag, " en_pulses"}, 32'(en_cnt - base_en), 32'(exp_en));
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " wb_en"}, 32'(wb_en), 32'd0);
    check({tag, " wb_sel"}, 32'(wb_sel), 32'd0);
    check({tag, " wb_dat"}, wb_dat, 32'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    nrst = 1'b1;

    // Unsigned general path
    launch(DIVU, 32'd100, 32'd7, 5'd5);
    finish_op("divu_100_7", 33, 32'd14, 5'd5, 1'b1);
    launch(REMU, 32'd100, 32'd7, 5'd5);
    finish_op("remu_100_7", 33, 32'd2, 5'd5, 1'b1);

    // Signed general path
    launch(DIV, 32'hFFFF_FFF9, 32'd2, 5'd1);
    finish_op("div_m7_2", 33, 32'hFFFF_FFFD, 5'd1, 1'b1);
    launch(REM, 32'hFFFF_FFF9, 32'd2, 5'd2);
    finish_op("rem_m7_2", 33, 32'hFFFF_FFFF, 5'd2, 1'b1);
    launch(DIV, 32'd7, 32'hFFFF_FFFE, 5'd3);
    finish_op("div_7_m2", 33, 32'hFFFF_FFFD, 5'd3, 1'b1);
    launch(REM, 32'd7, 32'hFFFF_FFFE, 5'd31);
    finish_op("rem_7_m2", 33, 32'd1, 5'd31, 1'b1);
    launch(DIVU, 32'h8000_0000, 32'd1, 5'd6);
    finish_op("divu_min_1", 33, 32'h8000_0000, 5'd6, 1'b1);

    // Special cases
    launch(DIVU, 32'd5, 32'd0, 5'd8);
    finish_op("divu_5_0", 1, 32'hFFFF_FFFF, 5'd8, 1'b1);
    launch(REMU, 32'd5, 32'd0, 5'd8);
    finish_op("remu_5_0", 1, 32'd5, 5'd8, 1'b1);
    launch(REM, 32'hFFFF_FFFB, 32'd0, 5'd9);
    finish_op("rem_m5_0", 1, 32'hFFFF_FFFB, 5'd9, 1'b1);
    launch(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    finish_op("div_ovf", 1, 32'h8000_0000, 5'd10, 1'b1);
    launch(REM, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    finish_op("rem_ovf", 1, 32'd0, 5'd10, 1'b1);

    // Flush at CALC cycle 10, then an immediate restart
    launch(DIVU, 32'd1000, 32'd3, 5'd7);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush busy", 32'(busy), 32'd0);
    check("flush done", 32'(done), 32'd0);
    #1;
    check("flush no_done", 32'(done_cnt - base_done), 32'd0);
    launch(DIVU, 32'd9, 32'd3, 5'd4);
    finish_op("after_flush", 33, 32'd3, 5'd4, 1'b1);

    // Flush and start together in IDLE: nothing accepted
    @(negedge clk);
    op = DIVU; rs1 = 32'd8; rs2 = 32'd2; rd = 5'd1; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start busy", 32'(busy), 32'd0);

    // Start pulses and operand changes while busy are ignored
    launch(DIVU, 32'd1000, 32'd3, 5'd3);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b1; op = REM; rs1 = 32'(i * 77 + 5); rs2 = 32'(i + 1); rd = 5'(i + 11);
      @(negedge clk);
      start = 1'b0;
    end
    finish_op("busy_ignore", 33, 32'd333, 5'd3, 1'b1);

    // Start during the DONE cycle is ignored
    launch(DIVU, 32'd50, 32'd5, 5'd2);
    wait_done("done_start", 33);
    check("done_start wb_dat", wb_dat, 32'd10);
    op = DIVU; rs1 = 32'd8; rs2 = 32'd2; rd = 5'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("done_start busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    #1;
    check("done_start pulses", 32'(done_cnt - base_done), 32'd1);
    check("done_start wb_sel", 32'(wb_sel), 32'd2);

    // Flush during the DONE cycle drops done at that edge
    launch(DIVU, 32'd5, 32'd0, 5'd12);
    wait_done("flush_done", 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_done done", 32'(done), 32'd0);
    check("flush_done busy", 32'(busy), 32'd0);

    // Reset at CALC cycle 20 aborts with no done
    launch(DIVU, 32'd1000, 32'd3, 5'd9);
    repeat (20) @(negedge clk);
    nrst = 1'b0;
    @(negedge clk);
    check_idle_zero("mid_reset");
    nrst = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("mid_reset no_done", 32'(done_cnt - base_done), 32'd0);

    // rd=0: done pulses, no write enable
    launch(DIVU, 32'hFFFF_FFFF, 32'd1, 5'd0);
    finish_op("rd0", 33, 32'hFFFF_FFFF, 5'd0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divide/remainder unit in the execute path.
- Consumes the two operand words read from the register file (rs1/rs2 data) together with the destination register index.
- Produces a one-cycle writeback request (enable, index, data) toward the register file write port.
- Radix-2 restoring algorithm: 1 quotient bit per cycle, plus special-case fast path.

Parameters:
XLEN, 32, operand/result width (only 32 is supported; the counter is sized clog2(XLEN))

Ports:
clk  input  1  clock, all state updates on rising edge
nrst  input  1  reset, synchronous, active-low
start  input  1  request; accepted only when busy=0
op  input  2  00=DIV, 01=DIVU, 10=REM, 11=REMU
rs1_dat  input  XLEN  dividend
rs2_dat  input  XLEN  divisor
rd_sel  input  5  destination register index
flush  input  1  abort any in-flight operation
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
wb_en  output  1  done && latched rd != 0
wb_sel  output  5  latched rd_sel
wb_dat  output  XLEN  result (quotient or remainder per op)

Behaviour:
Reset:
- nrst=0 at a rising edge forces state=IDLE and clears the counter, operand, partial-remainder and quotient registers.
- Outputs after reset: busy=0, done=0, wb_en=0, wb_sel=0, wb_dat=0.
- Reset mid-operation aborts the operation with no done.

States: IDLE, CALC, FIXUP, DONE.

Accept:
- In IDLE with start=1 and flush=0 at edge E0: latch op, rs1_dat, rs2_dat, rd_sel.
- Later input changes are ignored until the next accept.
- start while busy=1 is ignored and does not queue.

Special cases at accept (go straight to FIXUP):
- Divisor=0:
  - quotient = all ones (DIV and DIVU)
  - remainder = dividend
- DIV/REM with dividend=0x80000000 and divisor=0xFFFFFFFF:
  - quotient = 0x80000000
  - remainder = 0

General path:
- At accept, form unsigned magnitudes:
  - DIV/REM: absolute values (two's complement negate if MSB set).
  - DIVU/REMU: operands used as-is.
- Record negate_q = sign(rs1) XOR sign(rs2) and negate_r = sign(rs1); both are signed ops only.
- Counter loads XLEN-1 and the state goes to CALC.

CALC, one step per edge:
- Shift {rem, dividend} left by 1.
- Trial subtract: rem - divisor, using an XLEN+1-bit subtractor.
- If non-negative, keep the difference and shift in quotient bit 1; otherwise shift in 0.
- At count 0, go to FIXUP.

FIXUP:
- Apply negate_q to the quotient and negate_r to the remainder.
- Select the quotient (DIV/DIVU) or remainder (REM/REMU) into wb_dat.
- Go to DONE.

DONE:
- done=1 for exactly this one cycle, then IDLE.

Latency (accept edge E0; done is high between edges En and En+1):
- General: n=33.
  - CALC occupies E1..E32.
  - FIXUP transitions at E33.
  - busy high from after E0 through E34.
- Special: n=1.

Hold and back-to-back:
- wb_dat and wb_sel hold their values after done until the next accepted start.
- wb_en and done are low except during the DONE cycle.
- With rd_sel=0, done still pulses but wb_en stays 0.
- A start during the DONE cycle is ignored.
- The earliest next accept is the cycle after DONE (busy=0).

Flush:
- flush=1 in any state returns to IDLE at the next edge with no done and no wb_en, including flush during the DONE cycle (done is combinational from state, so it drops at that edge).
- flush and start in the same IDLE cycle: flush wins and nothing is accepted.
- Reset has priority over flush.

Arithmetic:
- All results are taken mod 2^XLEN.
- The negation of 0x80000000 magnitude is handled by the XLEN-bit unsigned path; DIVU of 0x80000000 by 1 gives 0x80000000.

Test Plan:
- DIVU 100/7 with rd=5 -> done exactly 33 cycles after accept; wb_dat=14, wb_sel=5, wb_en=1. Repeat as REMU -> wb_dat=2.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD. REM -> 0xFFFFFFFF. DIV 7 / 0xFFFFFFFE -> 0xFFFFFFFD. REM 7 / -2 -> 1.
- DIVU 5/0 -> done 1 cycle after accept, wb_dat=0xFFFFFFFF. REMU 5/0 -> wb_dat=5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0.
- Accept DIVU 1000/3, flush at cycle 10 of CALC -> busy=0 next cycle, no done/wb_en. Immediate new start DIVU 9/3 -> wb_dat=3 after 33 cycles.
- Start pulses while busy plus changing rs1_dat/rs2_dat mid-CALC -> exactly one done; result matches the originally latched operands. Start asserted during DONE is ignored.
- nrst=0 at CALC cycle 20 -> all outputs 0 after the edge, no done. DIVU 0xFFFFFFFF/1 with rd=0 -> done=1, wb_en=0, wb_dat=0xFFFFFFFF.
